// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Covers the register offsets, the status bit positions and the TX state encoding.
package mmio_uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // A programmed divisor of 0 would stall the baud counter, so it runs as 1.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO that uses pointers one bit wider than the address.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (count == (AW+1)'(DEPTH));
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter (8N1) that sits on the data-memory bus beside dmem.
// rd is zero when the block is not selected, so the core can OR it with the dmem read data.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          DIV_RESET  = 234,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          sel;
   logic [1:0]    off;
   logic          wr_tx, wr_status, wr_div;

   logic [15:0]   div;
   logic          overflow;

   logic          f_pop, f_full, f_empty;
   logic [7:0]    f_dout;
   logic [CW-1:0] f_count;

   tx_state_t     state, state_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [15:0]   baud, baud_n;
   logic [7:0]    shreg, shreg_n;
   logic [15:0]   div_l, div_l_n;
   logic          tx_n;

   assign sel       = (a[31:4] == BASE_ADDR[31:4]);
   assign off       = a[3:2];
   assign wr_tx     = we & sel & (off == OFF_TXDATA);
   assign wr_status = we & sel & (off == OFF_STATUS);
   assign wr_div    = we & sel & (off == OFF_DIV);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_tx),
      .din   (wd[7:0]),
      .pop   (f_pop),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_comb begin
      rd = '0;
      if (sel) begin
         case (off)
            OFF_STATUS: begin
               rd[ST_BUSY]  = (state != IDLE);
               rd[ST_FULL]  = f_full;
               rd[ST_EMPTY] = f_empty;
               rd[ST_OVF]   = overflow;
               rd[7:4]      = 4'(f_count);
            end
            OFF_DIV:  rd[15:0] = div;
            default:  rd = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= 16'(DIV_RESET);
         overflow <= 1'b0;
      end else begin
         if (wr_div) div <= wd[15:0];
         // A dropped push and a STATUS write never share a cycle (different offsets).
         if (wr_status)
            overflow <= 1'b0;
         else if (wr_tx && f_full && !f_pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         bitcnt <= '0;
         baud   <= '0;
         shreg  <= '0;
         div_l  <= '0;
         tx     <= 1'b1;
      end else begin
         state  <= state_n;
         bitcnt <= bitcnt_n;
         baud   <= baud_n;
         shreg  <= shreg_n;
         div_l  <= div_l_n;
         tx     <= tx_n;
      end
   end

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      baud_n   = baud;
      shreg_n  = shreg;
      div_l_n  = div_l;
      tx_n     = tx;
      f_pop    = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (!f_empty) begin
               f_pop   = 1'b1;
               shreg_n = f_dout;
               div_l_n = eff_div(div);
               baud_n  = eff_div(div) - 16'd1;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (baud == 16'd0) begin
               state_n  = DATA;
               bitcnt_n = 3'd0;
               baud_n   = div_l - 16'd1;
               tx_n     = shreg[0];
            end else begin
               baud_n = baud - 16'd1;
            end
         end
         DATA: begin
            if (baud == 16'd0) begin
               baud_n = div_l - 16'd1;
               if (bitcnt == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  shreg_n  = {1'b0, shreg[7:1]};
                  tx_n     = shreg[1];
                  bitcnt_n = bitcnt + 3'd1;
               end
            end else begin
               baud_n = baud - 16'd1;
            end
         end
         STOP: begin
            if (baud == 16'd0) begin
               // Chain straight into the next start bit so queued bytes stream without a gap.
               if (!f_empty) begin
                  f_pop   = 1'b1;
                  shreg_n = f_dout;
                  div_l_n = eff_div(div);
                  baud_n  = eff_div(div) - 16'd1;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end else begin
               baud_n = baud - 16'd1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx. It checks register decode, frame shape,
// streaming, overflow, divisor latching and reset.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        tx;

   int n_assert = 0;
   int n_fail   = 0;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .DIV_RESET  (234),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .we  (we),
      .a   (a),
      .wd  (wd),
      .rd  (rd),
      .tx  (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1; a = addr; wd = data;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      a = addr;
      #1 data = rd;
   endtask

   // Samples one frame starting at the next negedge; bits[i] is the level at the start of bit i.
   task automatic capture_frame(input int dv, input bit wait_start,
                                output logic [9:0] bits, output int glitches);
      int to;
      bits = 'x;
      glitches = 0;
      @(negedge clk);
      if (wait_start) begin
         to = 0;
         while (tx !== 1'b0 && to < 5000) begin
            @(negedge clk);
            to++;
         end
      end
      if (tx !== 1'b0) begin
         glitches = -1;
      end else begin
         for (int i = 0; i < 10*dv; i++) begin
            if (i > 0) @(negedge clk);
            if (i % dv == 0) bits[i/dv] = tx;
            else if (tx !== bits[i/dv]) glitches++;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1; we = 1'b0; a = '0; wd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04) begin n_fail++; $display("FAIL reset_status: got %h want 00000004", r); end
      n_assert++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
      bus_read(BASE + 8, r);
      n_assert++;
      if (r !== 32'd234) begin n_fail++; $display("FAIL reset_div: got %0d want 234", r); end
   endtask

   task automatic test_single();
      logic [31:0] r;
      logic [9:0]  bits;
      int          g;
      bus_write(BASE + 8, 32'd4);
      @(negedge clk);
      bus_read(BASE + 8, r);
      n_assert++;
      if (r !== 32'd4) begin n_fail++; $display("FAIL single_div: got %0d want 4", r); end
      bus_write(BASE, 32'h55);
      @(negedge clk);
      bus_read(BASE + 4, r);
      n_assert++;
      if (tx !== 1'b1 || r !== 32'h10) begin
         n_fail++; $display("FAIL single_accept: tx=%b status=%h want tx=1 status=00000010", tx, r);
      end
      capture_frame(4, 1'b0, bits, g);
      n_assert++;
      if (bits !== 10'b1_0101_0101_0 || g !== 0) begin
         n_fail++; $display("FAIL single_frame: bits=%b glitches=%0d want 1010101010 0", bits, g);
      end
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h05) begin n_fail++; $display("FAIL single_busy_last_stop: got %h want 00000005", r); end
      @(negedge clk);
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04 || tx !== 1'b1) begin
         n_fail++; $display("FAIL single_done: status=%h tx=%b want 00000004 1", r, tx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      logic [9:0]  bits [4];
      int          g [4];
      logic [31:0] r;
      bus_write(BASE + 8, 32'd2);
      fork
         begin
            for (int i = 0; i < 4; i++) capture_frame(2, (i == 0), bits[i], g[i]);
         end
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               we = 1'b1; a = BASE; wd = {24'h0, b[i]};
            end
            @(negedge clk);
            we = 1'b0;
            bus_read(BASE + 4, r);
            n_assert++;
            if (r !== 32'h31) begin n_fail++; $display("FAIL b2b_count: got %h want 00000031", r); end
         end
      join
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (bits[i] !== {1'b1, b[i], 1'b0} || g[i] !== 0) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: bits=%b glitches=%0d want %b 0", i, bits[i], g[i], {1'b1, b[i], 1'b0});
         end
      end
      @(negedge clk);
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04) begin n_fail++; $display("FAIL b2b_final: got %h want 00000004", r); end
   endtask

   task automatic test_overflow();
      logic [7:0]  b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [9:0]  bits [5];
      int          g [5];
      int          highs;
      logic [31:0] r;
      bus_write(BASE + 8, 32'd100);
      fork
         begin
            for (int i = 0; i < 5; i++) capture_frame(100, (i == 0), bits[i], g[i]);
            highs = 0;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (tx === 1'b1) highs++;
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               we = 1'b1; a = BASE; wd = {24'h0, b[i]};
            end
            @(negedge clk);
            we = 1'b0;
            bus_read(BASE + 4, r);
            n_assert++;
            if (r !== 32'h4B) begin n_fail++; $display("FAIL ovf_status: got %h want 0000004b", r); end
            bus_write(BASE + 4, 32'h0);
            @(negedge clk);
            bus_read(BASE + 4, r);
            n_assert++;
            if (r !== 32'h43) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000043", r); end
         end
      join
      for (int i = 0; i < 5; i++) begin
         n_assert++;
         if (bits[i] !== {1'b1, b[i], 1'b0} || g[i] !== 0) begin
            n_fail++;
            $display("FAIL ovf_frame%0d: bits=%b glitches=%0d want %b 0", i, bits[i], g[i], {1'b1, b[i], 1'b0});
         end
      end
      n_assert++;
      if (highs !== 300) begin n_fail++; $display("FAIL ovf_no_sixth: idle-high cycles %0d want 300", highs); end
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04) begin n_fail++; $display("FAIL ovf_final: got %h want 00000004", r); end
   endtask

   task automatic test_div_change();
      logic [9:0]  bits0, bits1;
      int          g0, g1;
      logic [31:0] r;
      bus_write(BASE + 8, 32'd3);
      fork
         begin
            capture_frame(3, 1'b1, bits0, g0);
            capture_frame(1, 1'b0, bits1, g1);
         end
         begin
            bus_write(BASE, 32'h0F);
            repeat (13) @(negedge clk);
            bus_write(BASE + 8, 32'd0);
            @(negedge clk);
            bus_read(BASE + 8, r);
            n_assert++;
            if (r !== 32'd0) begin n_fail++; $display("FAIL div_zero_read: got %0d want 0", r); end
            bus_write(BASE, 32'h96);
         end
      join
      n_assert++;
      if (bits0 !== 10'b1_0000_1111_0 || g0 !== 0) begin
         n_fail++; $display("FAIL div_old_frame: bits=%b glitches=%0d want 1000011110 0", bits0, g0);
      end
      n_assert++;
      if (bits1 !== 10'b1_1001_0110_0 || g1 !== 0) begin
         n_fail++; $display("FAIL div_new_frame: bits=%b glitches=%0d want 1100101100 0", bits1, g1);
      end
      @(negedge clk);
      n_assert++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL div_after: tx=%b want 1", tx); end
   endtask

   task automatic test_reset_mid_and_decode();
      logic [31:0] r;
      int          highs;
      bus_write(BASE + 8, 32'd4);
      bus_write(BASE, 32'h00);
      bus_write(BASE, 32'h00);
      repeat (21) @(negedge clk);
      n_assert++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_bit4: tx=%b want 0", tx); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_assert++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: tx=%b want 1", tx); end
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04) begin n_fail++; $display("FAIL rstmid_status: got %h want 00000004", r); end
      bus_read(BASE + 8, r);
      n_assert++;
      if (r !== 32'd234) begin n_fail++; $display("FAIL rstmid_div: got %0d want 234", r); end
      bus_read(BASE + 32'h10, r);
      n_assert++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL dec_unsel_read: got %h want 0", r); end
      bus_read(BASE + 32'hC, r);
      n_assert++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL dec_reserved_read: got %h want 0", r); end
      bus_read(BASE, r);
      n_assert++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL dec_txdata_read: got %h want 0", r); end
      bus_write(BASE + 32'h10, 32'h00);
      bus_write(BASE + 32'hC, 32'h00);
      bus_write(BASE + 32'h18, 32'd7);
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx === 1'b1) highs++;
      end
      n_assert++;
      if (highs !== 40) begin n_fail++; $display("FAIL dec_no_push_tx: high cycles %0d want 40", highs); end
      bus_read(BASE + 4, r);
      n_assert++;
      if (r !== 32'h04) begin n_fail++; $display("FAIL dec_no_push_status: got %h want 00000004", r); end
      bus_read(BASE + 8, r);
      n_assert++;
      if (r !== 32'd234) begin n_fail++; $display("FAIL dec_div_untouched: got %0d want 234", r); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_div_change();
      test_reset_mid_and_decode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds on the core's data-memory bus (`we`/`a`/`wd`/`rd`), in parallel with `dmem`. Software stores a byte to TXDATA; the block queues it in a small FIFO and serialises it as 8N1 on `tx`. Status and baud divisor are readable and writable through the same bus. The top level ORs `rd` with `dmem`'s read data, because `rd` is zero when the address is not selected.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: block base address; bits [3:0] must be 0.
- `DIV_RESET`, 234: reset value of the baud divisor in clocks per bit (27 MHz / 115200).
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two ≥ 2.

Ports:
- `clk`, in, 1: clock. One clock domain; this is the core clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `we`, in, 1: bus write strobe, sampled at posedge `clk`.
- `a`, in, 32: bus byte address; `a[1:0]` ignored.
- `wd`, in, 32: bus write data.
- `rd`, out, 32: bus read data, combinational from `a` and state.
- `tx`, out, 1: serial output, registered, idle high.

## Operation
- Select: `sel = (a[31:4] == BASE_ADDR[31:4])`. Register offset is `a[3:2]`. If `sel` is low, `rd = 0` and writes are ignored.
- Offset 0, TXDATA:
  - Write pushes `wd[7:0]`.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0 `busy` (FSM not IDLE)
  - bit1 `full`
  - bit2 `empty`
  - bit3 `overflow` (sticky)
  - bits[7:4] `count`
  - all other bits 0
  - Any write to STATUS clears `overflow`.
- Offset 2, DIV:
  - Write loads `wd[15:0]`.
  - Read returns `{16'b0, div}`.
  - A divisor of 0 is treated as 1.
- Offset 3: reserved. Reads 0; writes ignored.
- Push when full: data is dropped and `overflow` is set. Exception: if a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is not empty, pop the head into `shreg`, latch `div` into `div_l`, go to START.
  - START: `tx=0` for `div_l` cycles, then go to DATA with `bitcnt=0`.
  - DATA: `tx=shreg[0]` (LSB first), one bit per `div_l` cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx=1` for `div_l` cycles. Then, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Loads `div_l-1` on entry to each bit and decrements to 0.
  - The bit ends in the cycle the counter reads 0.
  - Counter is 16 bits wide; no wrap occurs because it reloads at 0.
- A DIV write during a frame affects only later frames, since `div_l` is latched at frame start.
- Reset:
  - `tx=1`, state IDLE, FIFO empty, `overflow=0`, `div=DIV_RESET`, counters 0.
  - Reset mid-frame aborts the frame; `tx` is high from the next edge.

## Timing
- Write accepted at edge k: the entry is visible in `count` and `empty` after edge k.
- If the FSM is IDLE at edge k+1, `tx` falls at edge k+1, so start-bit latency is 1 cycle after acceptance.
- Frame = exactly 10×`div_l` cycles: start, 8 data, stop.
- Back-to-back bytes produce a continuous stream; the next start bit begins at the edge right after the last stop cycle.
- `busy` rises with the start bit. It falls at the edge after the final stop cycle only when the FIFO is empty.
- `rd` is valid in the same cycle as `a`, with no wait states. This is required by the single-cycle core with synthesized memory.
- FIFO pop happens on the same edge as the IDLE→START or STOP→START transition.

## Structure
- Package `mmio_uart_pkg`:
  - offset constants `OFF_TXDATA`, `OFF_STATUS`, `OFF_DIV`
  - status bit indices `ST_BUSY`, `ST_FULL`, `ST_EMPTY`, `ST_OVF`
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
- Sub-module `sync_fifo`:
  - parameters: width 8, depth `FIFO_DEPTH`
  - ports: push/pop, full/empty/count
  - implementation: pointer wrap with one extra bit; simultaneous push+pop when full is legal
- The bus decode, registers, FSM and baud counter stay in `mmio_uart_tx`.

## Test plan
- **Reset state:** reset, then read `BASE+4` → `0x04` (empty); `tx=1`; read `BASE+8` → 234.
- **Single byte:** write DIV=4, then write 0x55 to `BASE+0`.
  - `tx` sequence: 0, 1,0,1,0,1,0,1,0, 1, with each level held exactly 4 cycles.
  - Total frame 40 cycles; `busy` clears after it.
- **Back-to-back:** DIV=2, push 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles.
  - Four frames of 20 cycles each with no gap.
  - STATUS `count` reads 3 one cycle after the last push (first byte already popped); final STATUS = 0x04.
- **Overflow:** DIV=100, push 6 bytes in consecutive cycles.
  - 1 byte popped, 4 queued, 1 dropped.
  - STATUS reads `full|busy|overflow|count=4` = 0x4B.
  - Writing STATUS clears bit3; only 5 frames are transmitted.
- **Divisor mid-frame and zero:** DIV=3, send 0x0F; write DIV=0 during bit 3.
  - Current frame stays at 3 cycles per bit.
  - Next byte uses 1 cycle per bit (10-cycle frame).
- **Reset mid-frame and decode:**
  - Assert `rst` during data bit 4: `tx=1` next edge, `count=0`.
  - Read `BASE+0x10` and `BASE+0xC` → 0.
  - Write to `BASE+0x10` → no push occurs.
